time_cmd_encoder: RTL and testbench

Parametrised successor to the clock-setting input stage. It takes seven raw, asynchronous push-button levels and synchronises and debounces each one. It generates press and auto-repeat events, then arbitrates them by fixed priority into the packed `{amount, opcode}` command word consumed by the time-keeping core, using a valid/ready handshake. It sits between the board buttons and the time accumulator.

---
 rtl/time_cmd_encoder.sv | 199 +++++++++++++++++++
 tb/tb_time_cmd_encoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_cmd_encoder.sv
// time_cmd_encoder: synchronises and debounces seven push buttons, turns
// presses and held-button auto-repeats into events, queues them in a
// pending register and issues them by fixed priority as packed
// {amount, opcode} commands over a valid/ready handshake.
module time_cmd_encoder #(
  parameter int TIME_BUFF_SIZE = 18,
  parameter int OPER_L         = 3,
  parameter int HOUR           = 3600,
  parameter int MINUTE         = 60,
  parameter int SECOND         = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_CYC   = 4,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_PERIOD  = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [6:0]                     BTN,
  output logic [TIME_BUFF_SIZE+OPER_L:0] OPER,
  output logic                           OPER_VALID,
  input  logic                           OPER_READY,
  output logic                           OVERFLOW
);

  localparam int OW      = TIME_BUFF_SIZE + OPER_L + 1;
  localparam int AW      = TIME_BUFF_SIZE + 1;
  localparam int DBW     = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW     = $clog2(RPT_MAX + 2);

  localparam logic [OPER_L-1:0] OP_RESET = OPER_L'(32'd0);
  localparam logic [OPER_L-1:0] OP_DEC   = OPER_L'(32'd1);
  localparam logic [OPER_L-1:0] OP_ADD   = OPER_L'(32'd2);

  // Amounts are zero-extended or truncated to the amount field width.
  localparam logic [AW-1:0] AMT_ZERO = AW'(32'd0);
  localparam logic [AW-1:0] AMT_HOUR = AW'(HOUR);
  localparam logic [AW-1:0] AMT_MIN  = AW'(MINUTE);
  localparam logic [AW-1:0] AMT_SEC  = AW'(SECOND);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } btn_state_t;

  // Command word for the highest-priority (lowest index) pending button.
  function automatic logic [OW-1:0] cmd_word(input logic [6:0] pend);
    logic [OW-1:0] w;
    casez (pend)
      7'b??????1: w = {AMT_ZERO, OP_RESET};
      7'b?????10: w = {AMT_HOUR, OP_ADD};
      7'b????100: w = {AMT_HOUR, OP_DEC};
      7'b???1000: w = {AMT_MIN,  OP_ADD};
      7'b??10000: w = {AMT_MIN,  OP_DEC};
      7'b?100000: w = {AMT_SEC,  OP_ADD};
      7'b1000000: w = {AMT_SEC,  OP_DEC};
      default:    w = {OW{1'b0}};
    endcase
    return w;
  endfunction

  logic [6:0]    ev_s;
  logic [6:0]    pending_r;
  logic [6:0]    win_oh_s;
  logic [6:0]    pend_clr_s;
  logic [6:0]    pend_nxt_s;
  logic          load_s;
  logic          ovf_set_s;
  logic [OW-1:0] cmd_s;

  for (genvar i = 0; i < 7; i++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_r;
    logic [DBW-1:0]         dcnt_r;
    logic                   deb_r;
    logic                   synced_s;
    logic                   flip_s;
    logic                   rise_s;

    assign synced_s = sync_r[SYNC_STAGES-1];
    // Flip on the cycle that completes DEBOUNCE_CYC consecutive differing samples.
    assign flip_s   = (synced_s != deb_r) && (dcnt_r == DBW'(DEBOUNCE_CYC - 1));
    assign rise_s   = flip_s & synced_s;

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], BTN[i]};
      end
    end

    // Count consecutive cycles the synchronised level differs; any agreement restarts.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dcnt_r <= {DBW{1'b0}};
        deb_r  <= 1'b0;
      end else if (synced_s == deb_r) begin
        dcnt_r <= {DBW{1'b0}};
      end else if (flip_s) begin
        dcnt_r <= {DBW{1'b0}};
        deb_r  <= synced_s;
      end else begin
        dcnt_r <= dcnt_r + DBW'(32'd1);
      end
    end

    if (i == 0) begin : g_reset_btn
      // RESET_TIME only ever produces a press event.
      assign ev_s[i] = rise_s;
    end else begin : g_fsm
      btn_state_t     st_r;
      logic [RCW-1:0] rcnt_r;
      logic           fall_s;
      logic           rpt_s;

      assign fall_s  = flip_s & ~synced_s;
      // A release on the same edge as an expiring counter suppresses the repeat.
      assign rpt_s   = (REPEAT_EN != 0) && (st_r == ST_HOLD) && !fall_s &&
                       (rcnt_r <= RCW'(32'd1));
      assign ev_s[i] = ((st_r == ST_IDLE) && rise_s) || rpt_s;

      // Press/hold state machine with the auto-repeat countdown.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          st_r   <= ST_IDLE;
          rcnt_r <= {RCW{1'b0}};
        end else begin
          case (st_r)
            ST_IDLE: begin
              if (rise_s) begin
                st_r   <= ST_HOLD;
                rcnt_r <= RCW'(REPEAT_DELAY);
              end
            end
            ST_HOLD: begin
              if (fall_s) begin
                st_r   <= ST_IDLE;
                rcnt_r <= {RCW{1'b0}};
              end else if (REPEAT_EN == 0) begin
                rcnt_r <= rcnt_r;
              end else if (rpt_s) begin
                rcnt_r <= RCW'(REPEAT_PERIOD);
              end else begin
                rcnt_r <= rcnt_r - RCW'(32'd1);
              end
            end
            default: begin
              st_r   <= ST_IDLE;
              rcnt_r <= {RCW{1'b0}};
            end
          endcase
        end
      end
    end
  end

  assign cmd_s = cmd_word(pending_r);

  // Pick the winner, clear it when loaded, merge new events and detect drops.
  always_comb begin
    win_oh_s = pending_r & (~pending_r + 7'd1);
    load_s   = (pending_r != 7'd0) && (!OPER_VALID || OPER_READY);
    if (load_s) begin
      pend_clr_s = pending_r & ~win_oh_s;
    end else begin
      pend_clr_s = pending_r;
    end
    if (ev_s[0]) begin
      // RESET_TIME flushes the queued inc/dec events without flagging overflow.
      pend_nxt_s = 7'b0000001;
      ovf_set_s  = pend_clr_s[0];
    end else begin
      pend_nxt_s = pend_clr_s | ev_s;
      ovf_set_s  = |(pend_clr_s & ev_s);
    end
  end

  // Pending register, sticky overflow and the registered output slot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_r  <= 7'd0;
      OVERFLOW   <= 1'b0;
      OPER       <= {OW{1'b0}};
      OPER_VALID <= 1'b0;
    end else begin
      pending_r <= pend_nxt_s;
      OVERFLOW  <= OVERFLOW | ovf_set_s;
      if (load_s) begin
        OPER       <= cmd_s;
        OPER_VALID <= 1'b1;
      end else if (OPER_READY) begin
        OPER_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_time_cmd_encoder.sv
// Directed testbench for time_cmd_encoder with default parameters.
module tb_time_cmd_encoder;

  logic        CLK;
  logic        RST_N;
  logic [6:0]  BTN;
  logic [21:0] OPER;
  logic        OPER_VALID;
  logic        OPER_READY;
  logic        OVERFLOW;

  int n_checks;
  int n_fail;
  int cyc;
  int t0;
  int          xrel[$];
  logic [21:0] xval[$];

  time_cmd_encoder dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN        (BTN),
    .OPER       (OPER),
    .OPER_VALID (OPER_VALID),
    .OPER_READY (OPER_READY),
    .OVERFLOW   (OVERFLOW)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Edge counter used to time transfers relative to stimulus start.
  always @(posedge CLK) cyc <= cyc + 1;

  // Record every handshake that will complete on the next rising edge.
  always @(negedge CLK) begin
    if (RST_N && OPER_VALID && OPER_READY) begin
      xrel.push_back(cyc - t0);
      xval.push_back(OPER);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_scenario(input logic ready, input logic [6:0] btn);
    xrel.delete();
    xval.delete();
    OPER_READY = ready;
    BTN = btn;
    t0 = cyc;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    BTN = 7'd0;
    OPER_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (OPER !== 22'd0 || OPER_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
      $display("FAIL reset_values: got oper=%0d valid=%b ovf=%b expected 0 0 0", OPER, OPER_VALID, OVERFLOW);
      n_fail++;
    end
    RST_N = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      n_checks++;
      if (OPER !== 22'd0 || OPER_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
        $display("FAIL idle_cycle%0d: got oper=%0d valid=%b ovf=%b expected 0 0 0", k, OPER, OPER_VALID, OVERFLOW);
        n_fail++;
      end
    end
  endtask

  task automatic test_single_press;
    start_scenario(1'b1, 7'b0001000);
    tick(10);
    BTN = 7'd0;
    tick(40);
    n_checks++;
    if (xrel.size() !== 1) begin
      $display("FAIL single_count: got %0d transfers expected 1", xrel.size());
      n_fail++;
    end
    if (xrel.size() > 0) begin
      n_checks++;
      if (xrel[0] !== 7) begin
        $display("FAIL single_latency: got cycle %0d expected 7", xrel[0]);
        n_fail++;
      end
      n_checks++;
      if (xval[0] !== 22'd482) begin
        $display("FAIL single_value: got %0d expected 482", xval[0]);
        n_fail++;
      end
    end
  endtask

  task automatic test_bounce;
    start_scenario(1'b1, 7'b0000000);
    for (int k = 0; k < 10; k++) begin
      BTN = (k % 2 == 0) ? 7'b0100000 : 7'b0000000;
      tick(2);
    end
    BTN = 7'd0;
    tick(40);
    n_checks++;
    if (xrel.size() !== 0) begin
      $display("FAIL bounce_count: got %0d transfers expected 0", xrel.size());
      n_fail++;
    end
    n_checks++;
    if (OVERFLOW !== 1'b0) begin
      $display("FAIL bounce_ovf: got %b expected 0", OVERFLOW);
      n_fail++;
    end
  endtask

  task automatic test_auto_repeat;
    int exp_rel[7];
    exp_rel = '{7, 23, 27, 31, 35, 39, 43};
    start_scenario(1'b1, 7'b0000100);
    tick(40);
    BTN = 7'd0;
    tick(40);
    n_checks++;
    if (xrel.size() !== 7) begin
      $display("FAIL repeat_count: got %0d transfers expected 7", xrel.size());
      n_fail++;
    end
    for (int k = 0; k < 7; k++) begin
      if (k < xrel.size()) begin
        n_checks++;
        if (xrel[k] !== exp_rel[k] || xval[k] !== 22'd28801) begin
          $display("FAIL repeat_xfer%0d: got cycle %0d value %0d expected cycle %0d value 28801",
                   k, xrel[k], xval[k], exp_rel[k]);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] exp_val[3];
    exp_val = '{22'd28802, 22'd482, 22'd10};
    start_scenario(1'b1, 7'b0101010);
    tick(10);
    BTN = 7'd0;
    tick(30);
    n_checks++;
    if (xrel.size() !== 3) begin
      $display("FAIL b2b_count: got %0d transfers expected 3", xrel.size());
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      if (k < xrel.size()) begin
        n_checks++;
        if (xrel[k] !== 7 + k || xval[k] !== exp_val[k]) begin
          $display("FAIL b2b_xfer%0d: got cycle %0d value %0d expected cycle %0d value %0d",
                   k, xrel[k], xval[k], 7 + k, exp_val[k]);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_priority_stall;
    start_scenario(1'b0, 7'b1000010);
    tick(10);
    BTN = 7'd0;
    tick(10);
    n_checks++;
    if (OPER_VALID !== 1'b1 || OPER !== 22'd28802) begin
      $display("FAIL stall_hold: got valid=%b oper=%0d expected 1 28802", OPER_VALID, OPER);
      n_fail++;
    end
    OPER_READY = 1'b1;
    tick(30);
    n_checks++;
    if (xrel.size() !== 2) begin
      $display("FAIL prio_count: got %0d transfers expected 2", xrel.size());
      n_fail++;
    end
    if (xrel.size() >= 2) begin
      n_checks++;
      if (xval[0] !== 22'd28802 || xval[1] !== 22'd9 || xrel[0] !== 20 || xrel[1] !== 21) begin
        $display("FAIL prio_order: got %0d@%0d %0d@%0d expected 28802@20 9@21",
                 xval[0], xrel[0], xval[1], xrel[1]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_flush;
    start_scenario(1'b0, 7'b1000010);
    tick(12);
    BTN = 7'b0000001;
    tick(10);
    BTN = 7'd0;
    tick(18);
    OPER_READY = 1'b1;
    tick(30);
    n_checks++;
    if (xrel.size() !== 2) begin
      $display("FAIL flush_count: got %0d transfers expected 2", xrel.size());
      n_fail++;
    end
    if (xrel.size() >= 2) begin
      n_checks++;
      if (xval[0] !== 22'd28802 || xval[1] !== 22'd0) begin
        $display("FAIL flush_order: got %0d then %0d expected 28802 then 0", xval[0], xval[1]);
        n_fail++;
      end
    end
    n_checks++;
    if (OVERFLOW !== 1'b0) begin
      $display("FAIL flush_ovf: got %b expected 0", OVERFLOW);
      n_fail++;
    end
  endtask

  task automatic test_overflow;
    start_scenario(1'b0, 7'b0001000);
    tick(25);
    n_checks++;
    if (OVERFLOW !== 1'b0) begin
      $display("FAIL ovf_early: got %b expected 0", OVERFLOW);
      n_fail++;
    end
    tick(5);
    n_checks++;
    if (OVERFLOW !== 1'b1) begin
      $display("FAIL ovf_set: got %b expected 1", OVERFLOW);
      n_fail++;
    end
    n_checks++;
    if (OPER_VALID !== 1'b1 || OPER !== 22'd482 || xrel.size() !== 0) begin
      $display("FAIL ovf_slot: got valid=%b oper=%0d xfers=%0d expected 1 482 0",
               OPER_VALID, OPER, xrel.size());
      n_fail++;
    end
    tick(30);
    BTN = 7'd0;
    tick(20);
    OPER_READY = 1'b1;
    tick(10);
    n_checks++;
    if (xrel.size() !== 2) begin
      $display("FAIL ovf_drain: got %0d transfers expected 2", xrel.size());
      n_fail++;
    end
    n_checks++;
    if (OVERFLOW !== 1'b1) begin
      $display("FAIL ovf_sticky: got %b expected 1", OVERFLOW);
      n_fail++;
    end
    RST_N = 1'b0;
    tick(2);
    n_checks++;
    if (OVERFLOW !== 1'b0 || OPER_VALID !== 1'b0 || OPER !== 22'd0) begin
      $display("FAIL ovf_reset: got ovf=%b valid=%b oper=%0d expected 0 0 0", OVERFLOW, OPER_VALID, OPER);
      n_fail++;
    end
    RST_N = 1'b1;
    tick(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    t0 = 0;
    RST_N = 1'b0;
    BTN = 7'd0;
    OPER_READY = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_back_to_back();
    test_priority_stall();
    test_reset_flush();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
